// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network sequencing and MAC datapath.
// The command struct is the record the MAC block consumes for each multiply-accumulate.
package nn_pkg;

    localparam int NN_ADDR_LEN  = 2;
    localparam int NN_DATA_LEN  = 16;
    localparam int NN_CNT_LEN   = 8;
    localparam int NN_WADDR_LEN = 12;

    // A zero neuron count marks the end of the topology list.
    localparam int TOPO_TERMINATOR = 0;

    typedef enum logic [2:0] {
        IDLE,
        RD_IN,
        WT_IN,
        RD_OUT,
        WT_OUT,
        ISSUE,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [NN_ADDR_LEN-1:0]  layer;
        logic [NN_CNT_LEN-1:0]   neuron;
        logic [NN_CNT_LEN-1:0]   in_idx;
        logic [NN_WADDR_LEN-1:0] waddr;
        logic                    first;
        logic                    last;
    } cmd_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Valid/ready MAC command channel between the layer sequencer (master)
// and the MAC/accumulator datapath (slave).
interface layer_sequencer_if #(
    parameter int ADDR_LEN  = 2,
    parameter int CNT_LEN   = 8,
    parameter int WADDR_LEN = 12
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_LEN-1:0]  cmd_layer;
    logic [CNT_LEN-1:0]   cmd_neuron;
    logic [CNT_LEN-1:0]   cmd_input;
    logic [WADDR_LEN-1:0] cmd_waddr;
    logic                 cmd_first;
    logic                 cmd_last;

    modport master (
        output cmd_valid, cmd_layer, cmd_neuron, cmd_input, cmd_waddr, cmd_first, cmd_last,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_layer, cmd_neuron, cmd_input, cmd_waddr, cmd_first, cmd_last,
        output cmd_ready
    );

endinterface

// File: rtl/nn_loop_counter.sv
// Two-level nested index counter: i (inner, input index) and j (outer, neuron index).
// wrap_o flags the final (j, i) pair so a step there returns both indices to zero.
module nn_loop_counter #(
    parameter int CNT_LEN = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic [CNT_LEN-1:0] n_in_i,
    input  logic [CNT_LEN-1:0] n_out_i,
    output logic [CNT_LEN-1:0] i_o,
    output logic [CNT_LEN-1:0] j_o,
    output logic               first_o,
    output logic               last_o,
    output logic               wrap_o
);

    logic [CNT_LEN-1:0] r_i;
    logic [CNT_LEN-1:0] r_j;
    logic [CNT_LEN-1:0] w_i_max;
    logic [CNT_LEN-1:0] w_j_max;

    assign w_i_max = n_in_i - CNT_LEN'(1);
    assign w_j_max = n_out_i - CNT_LEN'(1);

    assign i_o     = r_i;
    assign j_o     = r_j;
    assign first_o = (r_i == '0);
    assign last_o  = (r_i == w_i_max);
    assign wrap_o  = last_o && (r_j == w_j_max);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_i <= '0;
            r_j <= '0;
        end else if (clear_i) begin
            r_i <= '0;
            r_j <= '0;
        end else if (step_i) begin
            if (last_o) begin
                r_i <= '0;
                r_j <= wrap_o ? '0 : r_j + CNT_LEN'(1);
            end else begin
                r_i <= r_i + CNT_LEN'(1);
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the topology BRAM and issues one MAC command per (output neuron, input)
// for every adjacent layer pair, with a running weight address and first/last flags.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int ADDR_LEN  = NN_ADDR_LEN,
    parameter int DATA_LEN  = NN_DATA_LEN,
    parameter int CNT_LEN   = NN_CNT_LEN,
    parameter int WADDR_LEN = NN_WADDR_LEN
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                topo_ena_o,
    output logic [ADDR_LEN-1:0] topo_addr_o,
    input  logic [DATA_LEN-1:0] topo_data_i,
    layer_sequencer_if.master   cmd_if
);

    // Source layer index of the final possible pair (destination is the last BRAM word).
    localparam logic [ADDR_LEN-1:0] LAST_SRC_LAYER = ADDR_LEN'((2 ** ADDR_LEN) - 2);

    seq_state_t           r_state;
    seq_state_t           w_next;
    logic [ADDR_LEN-1:0]  r_l;
    logic [CNT_LEN-1:0]   r_n_in;
    logic [CNT_LEN-1:0]   r_n_out;
    logic [WADDR_LEN-1:0] r_waddr;
    logic                 r_err;

    logic                 w_zero;
    logic                 w_oversize;
    logic                 w_last_pair;
    logic                 w_clear;
    logic                 w_step;
    logic [CNT_LEN-1:0]   w_i;
    logic [CNT_LEN-1:0]   w_j;
    logic                 w_first;
    logic                 w_last;
    logic                 w_wrap;

    assign w_zero      = (topo_data_i == DATA_LEN'(TOPO_TERMINATOR));
    assign w_oversize  = |topo_data_i[DATA_LEN-1:CNT_LEN];
    assign w_last_pair = (r_l == LAST_SRC_LAYER);
    assign err_o       = r_err;

    nn_loop_counter #(
        .CNT_LEN (CNT_LEN)
    ) u_loop (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_clear),
        .step_i  (w_step),
        .n_in_i  (r_n_in),
        .n_out_i (r_n_out),
        .i_o     (w_i),
        .j_o     (w_j),
        .first_o (w_first),
        .last_o  (w_last),
        .wrap_o  (w_wrap)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next            = r_state;
        busy_o            = (r_state != IDLE);
        done_o            = 1'b0;
        topo_ena_o        = 1'b0;
        topo_addr_o       = '0;
        w_clear           = 1'b0;
        w_step            = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_layer  = '0;
        cmd_if.cmd_neuron = '0;
        cmd_if.cmd_input  = '0;
        cmd_if.cmd_waddr  = '0;
        cmd_if.cmd_first  = 1'b0;
        cmd_if.cmd_last   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) w_next = RD_IN;
            end
            RD_IN: begin
                topo_ena_o = 1'b1;
                w_next     = WT_IN;
            end
            WT_IN: begin
                w_next = (w_zero || w_oversize) ? DONE : RD_OUT;
            end
            RD_OUT: begin
                topo_ena_o  = 1'b1;
                topo_addr_o = r_l + ADDR_LEN'(1);
                w_next      = WT_OUT;
            end
            WT_OUT: begin
                if (w_zero || w_oversize) begin
                    w_next = DONE;
                end else begin
                    w_clear = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                // Fields are gated to zero outside ISSUE so idle outputs read as all-zero.
                cmd_if.cmd_valid  = 1'b1;
                cmd_if.cmd_layer  = r_l + ADDR_LEN'(1);
                cmd_if.cmd_neuron = w_j;
                cmd_if.cmd_input  = w_i;
                cmd_if.cmd_waddr  = r_waddr;
                cmd_if.cmd_first  = w_first;
                cmd_if.cmd_last   = w_last;
                if (cmd_if.cmd_ready) begin
                    w_step = 1'b1;
                    if (w_wrap) w_next = w_last_pair ? DONE : RD_OUT;
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_l     <= '0;
            r_n_in  <= '0;
            r_n_out <= '0;
            r_waddr <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_err   <= 1'b0;
                        r_waddr <= '0;
                        r_l     <= '0;
                    end
                end
                WT_IN: begin
                    r_n_in <= topo_data_i[CNT_LEN-1:0];
                    if (w_zero || w_oversize) r_err <= 1'b1;
                end
                WT_OUT: begin
                    r_n_out <= topo_data_i[CNT_LEN-1:0];
                    // A zero right after layer 0 means fewer than two layers; later it terminates.
                    if (w_oversize || (w_zero && (r_l == '0))) r_err <= 1'b1;
                end
                ISSUE: begin
                    if (cmd_if.cmd_ready) begin
                        r_waddr <= r_waddr + WADDR_LEN'(1);
                        if (w_wrap && !w_last_pair) begin
                            r_n_in <= r_n_out;
                            r_l    <= r_l + ADDR_LEN'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: table-driven topologies, hand-written
// timing/reset sequences, and randomized topologies checked against a loop-nest model.
`timescale 1ns/1ps
module tb_layer_sequencer;
    import nn_pkg::*;

    localparam int ADDR_LEN  = 2;
    localparam int DATA_LEN  = 16;
    localparam int CNT_LEN   = 8;
    localparam int WADDR_LEN = 12;

    logic                clk_i   = 1'b0;
    logic                reset_i = 1'b1;
    logic                start_i = 1'b0;
    logic                busy_o;
    logic                done_o;
    logic                err_o;
    logic                topo_ena_o;
    logic [ADDR_LEN-1:0] topo_addr_o;
    logic [DATA_LEN-1:0] topo_data_i = '0;
    logic [DATA_LEN-1:0] mem [4];

    layer_sequencer_if #(
        .ADDR_LEN  (ADDR_LEN),
        .CNT_LEN   (CNT_LEN),
        .WADDR_LEN (WADDR_LEN)
    ) cmd_if ();

    layer_sequencer #(
        .ADDR_LEN  (ADDR_LEN),
        .DATA_LEN  (DATA_LEN),
        .CNT_LEN   (CNT_LEN),
        .WADDR_LEN (WADDR_LEN)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .topo_ena_o  (topo_ena_o),
        .topo_addr_o (topo_addr_o),
        .topo_data_i (topo_data_i),
        .cmd_if      (cmd_if)
    );

    always #5 clk_i = ~clk_i;

    // Topology BRAM: one-cycle read latency.
    always @(posedge clk_i) if (topo_ena_o) topo_data_i <= mem[topo_addr_o];

    int   total = 0;
    int   bad   = 0;
    cmd_t exp_q[$];
    bit   exp_err;
    int   exp_reads;
    int   got_n;
    bit   got_err;

    typedef struct {
        logic [63:0] topo;
        bit          rand_ready;
        int          glitch_at;
        int          exp_n;
        bit          exp_e;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] topo4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic void load(input logic [63:0] t);
        for (int k = 0; k < 4; k++) mem[k] = t[16*k +: 16];
    endfunction

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.layer  = cmd_if.cmd_layer;
        c.neuron = cmd_if.cmd_neuron;
        c.in_idx = cmd_if.cmd_input;
        c.waddr  = cmd_if.cmd_waddr;
        c.first  = cmd_if.cmd_first;
        c.last   = cmd_if.cmd_last;
        return c;
    endfunction

    // Expected command list straight from the topology rules.
    function automatic void build_model();
        int   n_in;
        int   n_out;
        int   wa;
        cmd_t c;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_reads = 1;
        wa        = 0;
        n_in      = int'(mem[0]);
        if (n_in == 0 || n_in > 255) begin
            exp_err = 1'b1;
            return;
        end
        for (int l = 0; l < 3; l++) begin
            n_out = int'(mem[l+1]);
            exp_reads++;
            if (n_out == 0) begin
                if (l == 0) exp_err = 1'b1;
                return;
            end
            if (n_out > 255) begin
                exp_err = 1'b1;
                return;
            end
            for (int j = 0; j < n_out; j++) begin
                for (int i = 0; i < n_in; i++) begin
                    c.layer  = 2'(l + 1);
                    c.neuron = 8'(j);
                    c.in_idx = 8'(i);
                    c.waddr  = 12'(wa);
                    c.first  = (i == 0);
                    c.last   = (i == n_in - 1);
                    exp_q.push_back(c);
                    wa++;
                end
            end
            n_in = n_out;
        end
    endfunction

    task automatic run_sweep(input string tag, input bit rand_ready, input int glitch_at);
        cmd_t got;
        cmd_t held;
        bit   holding;
        bit   finished;
        int   idx;
        int   reads;
        build_model();
        holding  = 1'b0;
        finished = 1'b0;
        idx      = 0;
        reads    = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 20000 && !finished; cyc++) begin
            @(negedge clk_i);
            if (cyc == 1) start_i = 1'b0;
            if (cyc == glitch_at) start_i = 1'b1;
            else if (cyc == glitch_at + 1) start_i = 1'b0;
            if (topo_ena_o) reads++;
            if (done_o) finished = 1'b1;
            got = cur_cmd();
            if (cmd_if.cmd_valid) begin
                if (holding) check({tag, " stall stable"}, got, held);
                cmd_if.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (cmd_if.cmd_ready) begin
                    if (idx < exp_q.size()) check({tag, " cmd"}, got, exp_q[idx]);
                    else check({tag, " extra cmd"}, idx, exp_q.size());
                    idx++;
                    holding = 1'b0;
                end else begin
                    held    = got;
                    holding = 1'b1;
                end
            end else begin
                if (holding) check({tag, " valid held in stall"}, cmd_if.cmd_valid, 1);
                holding = 1'b0;
                cmd_if.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!finished) check({tag, " timeout waiting done"}, finished, 1);
        @(negedge clk_i);
        cmd_if.cmd_ready = 1'b0;
        check({tag, " single done pulse"}, done_o, 0);
        check({tag, " idle after done"}, busy_o, 0);
        check({tag, " err held"}, err_o, exp_err);
        check({tag, " cmd count"}, idx, exp_q.size());
        check({tag, " bram reads"}, reads, exp_reads);
        got_n   = idx;
        got_err = err_o;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        bit   seen;

        cmd_if.cmd_ready = 1'b0;
        for (int k = 0; k < 4; k++) mem[k] = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst busy",   busy_o, 0);
        check("rst done",   done_o, 0);
        check("rst err",    err_o, 0);
        check("rst ena",    topo_ena_o, 0);
        check("rst addr",   topo_addr_o, 0);
        check("rst valid",  cmd_if.cmd_valid, 0);
        check("rst cmd",    cur_cmd(), 0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Table-driven topologies
        vecs.push_back('{topo4(4, 3, 2, 0),        1'b0, -1, 18,   1'b0});
        vecs.push_back('{topo4(1, 2, 1, 3),        1'b0, -1, 7,    1'b0});
        vecs.push_back('{topo4(4, 3, 2, 0),        1'b1, -1, 18,   1'b0});
        vecs.push_back('{topo4(2, 0, 7, 7),        1'b0, -1, 0,    1'b1});
        vecs.push_back('{topo4(16'h100, 3, 2, 0),  1'b0, -1, 0,    1'b1});
        vecs.push_back('{topo4(4, 3, 2, 0),        1'b0,  8, 18,   1'b0});
        vecs.push_back('{topo4(3, 16'h101, 2, 0),  1'b0, -1, 0,    1'b1});
        vecs.push_back('{topo4(2, 3, 0, 5),        1'b0, -1, 6,    1'b0});
        vecs.push_back('{topo4(2, 2, 16'h200, 0),  1'b0, -1, 4,    1'b1});
        vecs.push_back('{topo4(0, 3, 3, 3),        1'b0, -1, 0,    1'b1});
        vecs.push_back('{topo4(64, 64, 2, 0),      1'b0, -1, 4224, 1'b0});
        foreach (vecs[n]) begin
            v = vecs[n];
            load(v.topo);
            run_sweep($sformatf("vec%0d", n), v.rand_ready, v.glitch_at);
            check($sformatf("vec%0d table count", n), got_n, v.exp_n);
            check($sformatf("vec%0d table err", n), got_err, v.exp_e);
        end

        // Cycle-exact timing and 2-cycle layer gap
        load(topo4(4, 3, 2, 0));
        cmd_if.cmd_ready = 1'b1;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk_i);
            if (cyc == 1) start_i = 1'b0;
            if (cyc == 1) begin
                check("t+1 ena", topo_ena_o, 1);
                check("t+1 addr", topo_addr_o, 0);
            end
            if (cyc == 2) check("t+2 ena", topo_ena_o, 0);
            if (cyc == 3) begin
                check("t+3 ena", topo_ena_o, 1);
                check("t+3 addr", topo_addr_o, 1);
            end
            if (cyc >= 4)
                check($sformatf("t+%0d valid", cyc), cmd_if.cmd_valid,
                      ((cyc >= 5 && cyc <= 16) || cyc >= 19) ? 1 : 0);
            if (cyc == 5) check("t+5 waddr", cmd_if.cmd_waddr, 0);
            if (cyc == 19) begin
                check("t+19 waddr", cmd_if.cmd_waddr, 12);
                check("t+19 layer", cmd_if.cmd_layer, 2);
            end
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk_i);
            if (!busy_o) seen = 1'b1;
        end
        check("timing drain", seen, 1);

        // Asynchronous reset at the 5th command, then a fresh sweep
        @(negedge clk_i);
        start_i = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (cmd_if.cmd_valid && cmd_if.cmd_waddr == 12'd4) seen = 1'b1;
        end
        check("reach 5th cmd", seen, 1);
        #2 reset_i = 1'b1;
        #1;
        check("midrst valid", cmd_if.cmd_valid, 0);
        check("midrst busy",  busy_o, 0);
        check("midrst ena",   topo_ena_o, 0);
        check("midrst cmd",   cur_cmd(), 0);
        check("midrst done",  done_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        run_sweep("after reset", 1'b0, -1);

        // Randomized topologies against the model
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 4; k++)
                mem[k] = ($urandom_range(0, 11) == 0) ? 16'h0100 + 16'($urandom_range(0, 3))
                                                      : 16'($urandom_range(0, 5));
            run_sweep($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
